// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//
// Two-port arbiter in front of the single-port data memory. The memory reads
// combinationally and writes on the rising edge, using the word index
// Address[RAM_SIZE_BIT+1:2].
//
// Port 0 is the pipeline MEM stage. Port 1 is a secondary master such as DMA,
// a loader or a debug port. The arbiter grants one access per cycle and drives
// the memory from the winning port. Read data comes back registered, one cycle
// after the accept. A wait counter limits how long port 1 can be starved.
//
// Ports
//   clk, reset                      clock, asynchronous active-high reset
//   pN_valid/we/addr/wdata   (in)   request from port N (N = 0, 1)
//   pN_ready                 (out)  request from port N accepted this cycle
//   pN_rsp_valid/rsp_err     (out)  response strobe and error flag for port N
//   rsp_rdata                (out)  read data for the port whose rsp_valid is high
//   MemRead, MemWrite,
//   Address, Write_data      (out)  memory drive, combinational from the winner
//   Read_data                (in)   memory read data (combinational)
//
// Optional build macro
//   DMEM_ARB_BOUND_CHECK_EN  When defined, an accepted access that is out of
//                            range (word index >= RAM_SIZE) or misaligned is
//                            not sent to the memory. Its response carries
//                            rsp_err = 1 and rsp_rdata = 0. When not defined,
//                            the rsp_err outputs are tied low.
// -----------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int RAM_SIZE     = 1089,
  parameter int RAM_SIZE_BIT = 13
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              p0_valid,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [ADDR_W-1:0] p0_wdata,
  output logic              p0_ready,
  output logic              p0_rsp_valid,
  output logic              p0_rsp_err,

  input  logic              p1_valid,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [ADDR_W-1:0] p1_wdata,
  output logic              p1_ready,
  output logic              p1_rsp_valid,
  output logic              p1_rsp_err,

  output logic [ADDR_W-1:0] rsp_rdata,

  output logic              MemRead,
  output logic              MemWrite,
  output logic [ADDR_W-1:0] Address,
  output logic [ADDR_W-1:0] Write_data,
  input  logic [ADDR_W-1:0] Read_data
);

  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [7:0]        starve_cnt_q, starve_cnt_d;
  logic              last_grant_q, last_grant_d;
  logic              p0_rsp_valid_q, p0_rsp_valid_d;
  logic              p1_rsp_valid_q, p1_rsp_valid_d;
  logic              p0_rsp_err_q, p0_rsp_err_d;
  logic              p1_rsp_err_q, p1_rsp_err_d;
  logic [ADDR_W-1:0] rsp_rdata_q, rsp_rdata_d;

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  logic              p1_prio;
  logic              gnt0, gnt1, win_any;
  logic              win_we;
  logic [ADDR_W-1:0] win_addr, win_wdata;
  logic              win_bad;

  // Port 1 gets priority only after waiting STARVE_LIMIT cycles. Otherwise
  // port 0 (the pipeline) wins a tie. Both grants are held low while reset is
  // asserted. This keeps the memory outputs at zero and blocks a write from
  // committing at a reset edge.
  assign p1_prio = (starve_cnt_q == LIMIT);
  assign gnt0    = !reset && p0_valid && (!p1_valid || !p1_prio);
  assign gnt1    = !reset && p1_valid && (!p0_valid ||  p1_prio);
  assign win_any = gnt0 || gnt1;

  assign p0_ready = gnt0;
  assign p1_ready = gnt1;

  always_comb begin
    win_we    = 1'b0;
    win_addr  = '0;
    win_wdata = '0;
    if (gnt1) begin
      win_we    = p1_we;
      win_addr  = p1_addr;
      win_wdata = p1_wdata;
    end else if (gnt0) begin
      win_we    = p0_we;
      win_addr  = p0_addr;
      win_wdata = p0_wdata;
    end
  end

`ifdef DMEM_ARB_BOUND_CHECK_EN
  // Compare one bit wider than the index, so a RAM_SIZE equal to 2**RAM_SIZE_BIT
  // is not truncated.
  localparam logic [RAM_SIZE_BIT:0] RAM_LIMIT = (RAM_SIZE_BIT+1)'(RAM_SIZE);
  logic [RAM_SIZE_BIT:0] win_idx;
  assign win_idx = {1'b0, win_addr[RAM_SIZE_BIT+1:2]};
  assign win_bad = win_any && ((win_idx >= RAM_LIMIT) || (win_addr[1:0] != 2'b00));
`else
  assign win_bad = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Memory drive
  // ---------------------------------------------------------------------------
  // A rejected access (bound-check build only) still drives Address, but the
  // strobes stay low so the memory ignores it.
  assign MemRead    = win_any && !win_we && !win_bad;
  assign MemWrite   = win_any &&  win_we && !win_bad;
  assign Address    = win_addr;
  assign Write_data = win_wdata;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // Starvation counter. It counts only the cycles in which port 1 waits. An
    // accept or a dropped request clears it.
    starve_cnt_d = starve_cnt_q;
    if (!p1_valid || gnt1) begin
      starve_cnt_d = 8'd0;
    end else if (starve_cnt_q != LIMIT) begin
      starve_cnt_d = starve_cnt_q + 8'd1;
    end

    last_grant_d = last_grant_q;
    if (win_any) begin
      last_grant_d = gnt1;
    end

    p0_rsp_valid_d = gnt0;
    p1_rsp_valid_d = gnt1;
    p0_rsp_err_d   = gnt0 && win_bad;
    p1_rsp_err_d   = gnt1 && win_bad;

    // Read data is captured only for good reads. Writes and rejected accesses
    // return zero. With no accept, the previous response data is held.
    rsp_rdata_d = rsp_rdata_q;
    if (win_any) begin
      rsp_rdata_d = (!win_we && !win_bad) ? Read_data : '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt_q   <= 8'd0;
      last_grant_q   <= 1'b0;
      p0_rsp_valid_q <= 1'b0;
      p1_rsp_valid_q <= 1'b0;
      p0_rsp_err_q   <= 1'b0;
      p1_rsp_err_q   <= 1'b0;
      rsp_rdata_q    <= '0;
    end else begin
      starve_cnt_q   <= starve_cnt_d;
      last_grant_q   <= last_grant_d;
      p0_rsp_valid_q <= p0_rsp_valid_d;
      p1_rsp_valid_q <= p1_rsp_valid_d;
      p0_rsp_err_q   <= p0_rsp_err_d;
      p1_rsp_err_q   <= p1_rsp_err_d;
      rsp_rdata_q    <= rsp_rdata_d;
    end
  end

  assign p0_rsp_valid = p0_rsp_valid_q;
  assign p1_rsp_valid = p1_rsp_valid_q;
  assign p0_rsp_err   = p0_rsp_err_q;
  assign p1_rsp_err   = p1_rsp_err_q;
  assign rsp_rdata    = rsp_rdata_q;

  // last_grant is a debug-only register, and the sizing parameters are not
  // read by every build. This sink keeps them referenced.
  logic unused_ok;
  assign unused_ok = &{1'b0, last_grant_q, 32'(RAM_SIZE), 32'(RAM_SIZE_BIT)};

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

  logic        clk;
  logic        reset;
  logic        p0_valid, p0_we, p0_ready, p0_rsp_valid, p0_rsp_err;
  logic [31:0] p0_addr, p0_wdata;
  logic        p1_valid, p1_we, p1_ready, p1_rsp_valid, p1_rsp_err;
  logic [31:0] p1_addr, p1_wdata;
  logic [31:0] rsp_rdata;
  logic        MemRead, MemWrite;
  logic [31:0] Address, Write_data, Read_data;

`ifdef DMEM_ARB_BOUND_CHECK_EN
  localparam bit BC = 1'b1;
`else
  localparam bit BC = 1'b0;
`endif

  dmem_arbiter #(
    .ADDR_W(32), .STARVE_LIMIT(4), .RAM_SIZE(1089), .RAM_SIZE_BIT(13)
  ) dut (
    .clk(clk), .reset(reset),
    .p0_valid(p0_valid), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_ready(p0_ready), .p0_rsp_valid(p0_rsp_valid), .p0_rsp_err(p0_rsp_err),
    .p1_valid(p1_valid), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_ready(p1_ready), .p1_rsp_valid(p1_rsp_valid), .p1_rsp_err(p1_rsp_err),
    .rsp_rdata(rsp_rdata),
    .MemRead(MemRead), .MemWrite(MemWrite), .Address(Address),
    .Write_data(Write_data), .Read_data(Read_data)
  );

  // Memory model: combinational read, posedge write, word index Address[14:2].
  logic [31:0] mem [0:8191];
  assign Read_data = mem[Address[14:2]];
  always @(posedge clk) begin
    if (MemWrite) mem[Address[14:2]] <= Write_data;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  typedef struct {
    logic        p0v, p0we;
    logic [31:0] p0a, p0d;
    logic        p1v, p1we;
    logic [31:0] p1a, p1d;
    logic        r0, r1, mr, mw;
    logic [31:0] addr;
    logic        rv0, rv1, e0, e1;
    logic [31:0] rdata;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input logic p0v, input logic p0we, input logic [31:0] p0a, input logic [31:0] p0d,
    input logic p1v, input logic p1we, input logic [31:0] p1a, input logic [31:0] p1d,
    input logic r0, input logic r1, input logic mr, input logic mw, input logic [31:0] addr,
    input logic rv0, input logic rv1, input logic e0, input logic e1, input logic [31:0] rdata);
    vec_t v;
    v.p0v = p0v; v.p0we = p0we; v.p0a = p0a; v.p0d = p0d;
    v.p1v = p1v; v.p1we = p1we; v.p1a = p1a; v.p1d = p1d;
    v.r0 = r0; v.r1 = r1; v.mr = mr; v.mw = mw; v.addr = addr;
    v.rv0 = rv0; v.rv1 = rv1; v.e0 = e0; v.e1 = e1; v.rdata = rdata;
    return v;
  endfunction

  task automatic idle_inputs();
    p0_valid = 0; p0_we = 0; p0_addr = 0; p0_wdata = 0;
    p1_valid = 0; p1_we = 0; p1_addr = 0; p1_wdata = 0;
  endtask

  localparam logic [31:0] DB = 32'hDEADBEEF;
  localparam logic [31:0] A5 = 32'h5A5A5A5A;

  initial begin
    for (int i = 0; i < 8192; i++) mem[i] = 32'd0;
    idle_inputs();
    reset = 1'b1;

    // Columns: p0{v,we,a,d} p1{v,we,a,d} | ready0 ready1 MemRead MemWrite Address
    //          | rsp_valid0 rsp_valid1 err0 err1 rsp_rdata (response of previous row)
    // Basic write/read on port 0 and port 1, then back-to-back reads.
    vecs.push_back(mk(1,1,32'h10,DB, 0,0,0,0,   1,0,0,1,32'h10, 0,0,0,0,0));
    vecs.push_back(mk(1,0,32'h10,0,  0,0,0,0,   1,0,1,0,32'h10, 1,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,       0,0,0,0,   0,0,0,0,0,      1,0,0,0,DB));
    vecs.push_back(mk(0,0,0,0,       1,1,32'h20,A5, 0,1,0,1,32'h20, 0,0,0,0,DB));
    vecs.push_back(mk(0,0,0,0,       1,0,32'h20,0,  0,1,1,0,32'h20, 0,1,0,0,0));
    vecs.push_back(mk(1,1,32'h0,1,   0,0,0,0,   1,0,0,1,32'h0,  0,1,0,0,A5));
    vecs.push_back(mk(1,1,32'h4,2,   0,0,0,0,   1,0,0,1,32'h4,  1,0,0,0,0));
    vecs.push_back(mk(1,1,32'h8,3,   0,0,0,0,   1,0,0,1,32'h8,  1,0,0,0,0));
    vecs.push_back(mk(1,0,32'h0,0,   0,0,0,0,   1,0,1,0,32'h0,  1,0,0,0,0));
    vecs.push_back(mk(1,0,32'h4,0,   0,0,0,0,   1,0,1,0,32'h4,  1,0,0,0,1));
    vecs.push_back(mk(1,0,32'h8,0,   0,0,0,0,   1,0,1,0,32'h8,  1,0,0,0,2));
    vecs.push_back(mk(0,0,0,0,       0,0,0,0,   0,0,0,0,0,      1,0,0,0,3));
    vecs.push_back(mk(0,0,0,0,       0,0,0,0,   0,0,0,0,0,      0,0,0,0,3));
    // Both ports valid continuously: 4 grants to p0, then 1 to p1, twice.
    vecs.push_back(mk(1,0,0,0, 1,0,32'h20,0, 1,0,1,0,32'h0,  0,0,0,0,3));
    vecs.push_back(mk(1,0,0,0, 1,0,32'h20,0, 1,0,1,0,32'h0,  1,0,0,0,1));
    vecs.push_back(mk(1,0,0,0, 1,0,32'h20,0, 1,0,1,0,32'h0,  1,0,0,0,1));
    vecs.push_back(mk(1,0,0,0, 1,0,32'h20,0, 1,0,1,0,32'h0,  1,0,0,0,1));
    vecs.push_back(mk(1,0,0,0, 1,0,32'h20,0, 0,1,1,0,32'h20, 1,0,0,0,1));
    vecs.push_back(mk(1,0,0,0, 1,0,32'h20,0, 1,0,1,0,32'h0,  0,1,0,0,A5));
    vecs.push_back(mk(1,0,0,0, 1,0,32'h20,0, 1,0,1,0,32'h0,  1,0,0,0,1));
    vecs.push_back(mk(1,0,0,0, 1,0,32'h20,0, 1,0,1,0,32'h0,  1,0,0,0,1));
    vecs.push_back(mk(1,0,0,0, 1,0,32'h20,0, 1,0,1,0,32'h0,  1,0,0,0,1));
    vecs.push_back(mk(1,0,0,0, 1,0,32'h20,0, 0,1,1,0,32'h20, 1,0,0,0,1));
    vecs.push_back(mk(0,0,0,0, 0,0,0,0,      0,0,0,0,0,      0,1,0,0,A5));
    // Out-of-range write (index 1089) and misaligned read on port 1.
    vecs.push_back(mk(0,0,0,0, 1,1,32'h1104,32'hABCD, 0,1,0,!BC,32'h1104, 0,0,0,0,A5));
    vecs.push_back(mk(0,0,0,0, 1,0,32'h2,0,  0,1,!BC,0,32'h2, 0,1,0,BC,0));
    vecs.push_back(mk(0,0,0,0, 0,0,0,0,      0,0,0,0,0,       0,1,0,BC,(BC ? 32'd0 : 32'd1)));
    vecs.push_back(mk(0,0,0,0, 0,0,0,0,      0,0,0,0,0,       0,0,0,0,(BC ? 32'd0 : 32'd1)));

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rsp_valid0", {31'd0, p0_rsp_valid}, 0);
    chk("reset_rsp_valid1", {31'd0, p1_rsp_valid}, 0);
    chk("reset_rdata", rsp_rdata, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < vecs.size(); i++) begin
      p0_valid = vecs[i].p0v; p0_we = vecs[i].p0we; p0_addr = vecs[i].p0a; p0_wdata = vecs[i].p0d;
      p1_valid = vecs[i].p1v; p1_we = vecs[i].p1we; p1_addr = vecs[i].p1a; p1_wdata = vecs[i].p1d;
      #1;
      chk($sformatf("v%0d_p0_ready", i),     {31'd0, p0_ready},     {31'd0, vecs[i].r0});
      chk($sformatf("v%0d_p1_ready", i),     {31'd0, p1_ready},     {31'd0, vecs[i].r1});
      chk($sformatf("v%0d_MemRead", i),      {31'd0, MemRead},      {31'd0, vecs[i].mr});
      chk($sformatf("v%0d_MemWrite", i),     {31'd0, MemWrite},     {31'd0, vecs[i].mw});
      chk($sformatf("v%0d_Address", i),      Address,               vecs[i].addr);
      chk($sformatf("v%0d_p0_rsp_valid", i), {31'd0, p0_rsp_valid}, {31'd0, vecs[i].rv0});
      chk($sformatf("v%0d_p1_rsp_valid", i), {31'd0, p1_rsp_valid}, {31'd0, vecs[i].rv1});
      chk($sformatf("v%0d_p0_rsp_err", i),   {31'd0, p0_rsp_err},   {31'd0, vecs[i].e0});
      chk($sformatf("v%0d_p1_rsp_err", i),   {31'd0, p1_rsp_err},   {31'd0, vecs[i].e1});
      chk($sformatf("v%0d_rsp_rdata", i),    rsp_rdata,             vecs[i].rdata);
      $display("vec %0d: p0 v=%0b we=%0b a=%08h | p1 v=%0b we=%0b a=%08h | rdy=%0b%0b rsp=%0b%0b rdata=%08h",
               i, p0_valid, p0_we, p0_addr, p1_valid, p1_we, p1_addr,
               p0_ready, p1_ready, p0_rsp_valid, p1_rsp_valid, rsp_rdata);
      @(posedge clk); #1;
    end

    // Reset in the middle of operation. A p0 read is accepted, so its response
    // is pending. Then reset rises together with a p0 write to 0x30.
    idle_inputs();
    p0_valid = 1; p0_addr = 32'h0;
    @(posedge clk); #1;
    p0_we = 1; p0_addr = 32'h30; p0_wdata = 32'h77;
    reset = 1'b1;
    #1;
    chk("rst_p0_ready", {31'd0, p0_ready}, 0);
    chk("rst_MemWrite", {31'd0, MemWrite}, 0);
    chk("rst_MemRead", {31'd0, MemRead}, 0);
    chk("rst_Address", Address, 0);
    chk("rst_Write_data", Write_data, 0);
    chk("rst_p0_rsp_valid", {31'd0, p0_rsp_valid}, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    idle_inputs();
    @(posedge clk); #1;
    chk("post_rst_p0_rsp_valid", {31'd0, p0_rsp_valid}, 0);
    chk("post_rst_mem30", mem[12], 0);
    p0_valid = 1; p0_addr = 32'h30;
    @(posedge clk); #1;
    idle_inputs();
    chk("post_rst_read30_valid", {31'd0, p0_rsp_valid}, 1);
    chk("post_rst_read30_data", rsp_rdata, 0);
    $display("reset sequence: rsp_valid=%0b rdata=%08h", p0_rsp_valid, rsp_rdata);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
